// File: rtl/db_sao_offset_engine.sv
// SAO offset engine: iterative subtract divider per class, distortion accumulation and BO best 4-band window search.
// Optional macro SAO_EO_SIGN_EN: EO categories 0/1 are forced to offset >= 0 and 2/3 to <= 0.
module db_sao_offset_engine #(
  parameter int DIFF_WIDTH = 20,
  parameter int NUM_WIDTH  = 13,
  parameter int OFF_WIDTH  = 4,
  parameter int MAX_OFFSET = 7,
  parameter int DIS_WIDTH  = 25,
  parameter int ACC_WIDTH  = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [DIFF_WIDTH-1:0]  b_state_i,
  input  logic [NUM_WIDTH-1:0]   b_num_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*OFF_WIDTH-1:0] offsets_o,
  output logic [ACC_WIDTH-1:0]   dist_o,
  output logic [4:0]             band_pos_o
);
  localparam int PROD_W = DIFF_WIDTH + NUM_WIDTH + 2*OFF_WIDTH;
  localparam int WIN_W  = DIS_WIDTH + 2;
  localparam logic signed [ACC_WIDTH:0] SAT_POS = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_NEG = -SAT_POS;

  typedef enum logic [2:0] {IDLE, WAIT, DIV, DIST, FIN} state_t;

  state_t                        state;
  logic                          mode;
  logic [4:0]                    cnt;
  logic signed [DIFF_WIDTH-1:0]  st;
  logic [NUM_WIDTH-1:0]          num;
  logic [DIFF_WIDTH-1:0]         mag, rem;
  logic [OFF_WIDTH-1:0]          k;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [OFF_WIDTH-1:0]   hist_off [3];
  logic signed [DIS_WIDTH-1:0]   hist_d [4];
  logic signed [WIN_W-1:0]       win, best_sum;
  logic [4:0]                    best_pos;
  logic [4*OFF_WIDTH-1:0]        best_off;

  logic signed [OFF_WIDTH-1:0]   off;
  logic signed [PROD_W-1:0]      num_x, off_x, st_x;
  logic signed [DIS_WIDTH-1:0]   d;
  logic signed [ACC_WIDTH:0]     acc_sum;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic signed [WIN_W-1:0]       win_next;
  logic [4*OFF_WIDTH-1:0]        cur_off;
  logic [DIFF_WIDTH:0]           rem_try;
  logic [DIFF_WIDTH-1:0]         in_mag;
  logic                          last, better, div_step, sign_viol;

  always_comb begin
    off      = st[DIFF_WIDTH-1] ? -$signed(k) : $signed(k);
    num_x    = PROD_W'($signed({1'b0, num}));
    off_x    = PROD_W'(off);
    st_x     = PROD_W'(st);
    d        = DIS_WIDTH'(num_x * off_x * off_x - ((st_x * off_x) <<< 1));
    acc_sum  = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(d);
    if (acc_sum > SAT_POS)      acc_next = SAT_POS[ACC_WIDTH-1:0];
    else if (acc_sum < SAT_NEG) acc_next = SAT_NEG[ACC_WIDTH-1:0];
    else                        acc_next = acc_sum[ACC_WIDTH-1:0];
    // hist_d[3] is the distortion of the entry leaving the 4-band window
    win_next = win + WIN_W'(d) - WIN_W'(hist_d[3]);
    cur_off  = {off, hist_off[0], hist_off[1], hist_off[2]};
    last     = mode ? (cnt == 5'd31) : (cnt == 5'd3);
    better   = (cnt == 5'd3) || ((cnt > 5'd3) && (win_next < best_sum));
    rem_try  = {1'b0, rem} + (DIFF_WIDTH+1)'(num);
    div_step = (rem_try <= {1'b0, mag}) && (k < OFF_WIDTH'(MAX_OFFSET));
    in_mag   = b_state_i[DIFF_WIDTH-1] ? -b_state_i : b_state_i;
`ifdef SAO_EO_SIGN_EN
    sign_viol = !mode && (cnt[1] ? (!b_state_i[DIFF_WIDTH-1] && (|b_state_i))
                                 : b_state_i[DIFF_WIDTH-1]);
`else
    sign_viol = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;  mode <= 1'b0;  cnt <= '0;
      st <= '0;  num <= '0;  mag <= '0;  rem <= '0;  k <= '0;  acc <= '0;
      for (int i = 0; i < 4; i++) hist_d[i] <= '0;
      for (int i = 0; i < 3; i++) hist_off[i] <= '0;
      win <= '0;  best_sum <= '0;  best_pos <= '0;  best_off <= '0;
      done_o <= 1'b0;  offsets_o <= '0;  dist_o <= '0;  band_pos_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state <= WAIT;  mode <= mode_i;  cnt <= '0;  acc <= '0;
          win <= '0;  best_sum <= '0;  best_pos <= '0;  best_off <= '0;
          for (int i = 0; i < 4; i++) hist_d[i] <= '0;
          for (int i = 0; i < 3; i++) hist_off[i] <= '0;
        end
        WAIT: if (valid_i) begin
          st <= b_state_i;  num <= b_num_i;  mag <= in_mag;  k <= '0;  rem <= '0;
          state <= ((b_num_i == '0) || sign_viol) ? DIST : DIV;
        end
        DIV: if (div_step) begin
          k   <= k + OFF_WIDTH'(1);
          rem <= rem_try[DIFF_WIDTH-1:0];
        end else begin
          state <= DIST;
        end
        DIST: begin
          acc <= acc_next;  cnt <= cnt + 5'd1;  win <= win_next;
          hist_d[0] <= d;  hist_d[1] <= hist_d[0];  hist_d[2] <= hist_d[1];  hist_d[3] <= hist_d[2];
          hist_off[0] <= off;  hist_off[1] <= hist_off[0];  hist_off[2] <= hist_off[1];
          if (better) begin
            best_sum <= win_next;  best_pos <= cnt - 5'd3;  best_off <= cur_off;
          end
          if (last) begin
            state  <= FIN;
            done_o <= 1'b1;
            if (mode) begin
              offsets_o  <= better ? cur_off : best_off;
              dist_o     <= ACC_WIDTH'(better ? win_next : best_sum);
              band_pos_o <= better ? (cnt - 5'd3) : best_pos;
            end else begin
              offsets_o  <= cur_off;
              dist_o     <= acc_next;
              band_pos_o <= '0;
            end
          end else begin
            state <= WAIT;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o = (state == WAIT);
  assign busy_o  = (state != IDLE);
endmodule

// File: tb/tb_db_sao_offset_engine.sv
// Bench for db_sao_offset_engine: directed and random EO/BO runs against an arithmetic reference model.
`timescale 1ns/1ps
module tb_db_sao_offset_engine;
  localparam int MAXO = 7;

  logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, mode_i = 1'b0, valid_i = 1'b0;
  logic        ready_o, busy_o, done_o;
  logic [19:0] b_state_i = '0;
  logic [12:0] b_num_i = '0;
  logic [15:0] offsets_o;
  logic [27:0] dist_o;
  logic [4:0]  band_pos_o;

  int n_vec = 0, n_err = 0;
  int st_a[32], num_a[32], exp_gap[32], obs_gap[32];
  logic [15:0] exp_off, obs_off;
  longint      exp_dist;
  logic [27:0] obs_dist;
  logic [4:0]  exp_pos, obs_pos;
  logic        obs_done, obs_done_after, obs_busy_after;

  db_sao_offset_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .valid_i(valid_i),
    .ready_o(ready_o), .b_state_i(b_state_i), .b_num_i(b_num_i), .busy_o(busy_o),
    .done_o(done_o), .offsets_o(offsets_o), .dist_o(dist_o), .band_pos_o(band_pos_o)
  );

  always #5 clk = ~clk;

  // Reference: offset = sign * min(|s| / n, MAX), d = n*off^2 - 2*s*off, then EO sum or BO best window.
  task automatic model_run(input bit m);
    int n = m ? 32 : 4;
    int offs[32];
    longint ds[32];
    longint acc = 0, best = 0, win, a, dfull;
    int k, p;
    bit viol;
    for (int i = 0; i < n; i++) begin
      a = (st_a[i] < 0) ? -longint'(st_a[i]) : longint'(st_a[i]);
      k = (num_a[i] == 0) ? 0 : int'(a / num_a[i]);
      if (k > MAXO) k = MAXO;
      viol = 1'b0;
`ifdef SAO_EO_SIGN_EN
      viol = !m && ((i < 2 && st_a[i] < 0) || (i >= 2 && st_a[i] > 0));
`endif
      if (viol) k = 0;
      offs[i] = (st_a[i] < 0) ? -k : k;
      dfull = longint'(num_a[i]) * offs[i] * offs[i] - 2 * longint'(st_a[i]) * offs[i];
      ds[i] = (dfull <<< 39) >>> 39;
      exp_gap[i] = (num_a[i] == 0 || viol) ? 1 : k + 2;
      acc += ds[i];
      if (acc > 134217727) acc = 134217727;
      if (acc < -134217727) acc = -134217727;
    end
    p = 0;
    if (m) begin
      for (int s = 0; s <= 28; s++) begin
        win = ds[s] + ds[s+1] + ds[s+2] + ds[s+3];
        if (s == 0 || win < best) begin best = win; p = s; end
      end
      exp_dist = best;
    end else begin
      exp_dist = acc;
    end
    exp_pos = 5'(p);
    for (int j = 0; j < 4; j++) exp_off[4*j +: 4] = 4'(offs[p+j]);
  endtask

  task automatic gen_random(input bit m);
    for (int i = 0; i < (m ? 32 : 4); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        st_a[i]  = int'($urandom_range(0, 1048575)) - 524288;
        num_a[i] = int'($urandom_range(0, 8191));
      end else begin
        st_a[i]  = int'($urandom_range(0, 2000)) - 1000;
        num_a[i] = int'($urandom_range(0, 300));
      end
    end
  endtask

  // Drives one full run (valid held high, next entry presented right after each handshake) and records outputs.
  task automatic do_run(input bit m, input bit inject);
    int n = m ? 32 : 4;
    int t;
    obs_done = 1'b0;
    @(negedge clk); start_i = 1'b1; mode_i = m;
    @(negedge clk); start_i = 1'b0;
    valid_i = 1'b1; b_state_i = 20'(st_a[0]); b_num_i = 13'(num_a[0]);
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!ready_o && t < 50) begin @(negedge clk); t++; end
      if (!ready_o) begin
        n_err++; n_vec++;
        $display("FAIL ready_timeout entry=%0d ready=%0b required=1", i, ready_o);
        valid_i = 1'b0;
        return;
      end
      @(negedge clk);
      if (i + 1 < n) begin b_state_i = 20'(st_a[i+1]); b_num_i = 13'(num_a[i+1]); end
      else valid_i = 1'b0;
      t = 0;
      while (!ready_o && !done_o && t < 50) begin
        if (inject) begin start_i = (t == 0); mode_i = (t == 0) ? !m : m; end
        @(negedge clk); t++;
      end
      start_i = 1'b0; mode_i = m;
      obs_gap[i] = t;
    end
    obs_done = done_o;
    obs_off = offsets_o; obs_dist = dist_o; obs_pos = band_pos_o;
    @(negedge clk);
    obs_done_after = done_o; obs_busy_after = busy_o;
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({busy_o, ready_o, done_o, offsets_o, dist_o, band_pos_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%0b ready=%0b done=%0b off=%h dist=%h pos=%0d required all 0",
               busy_o, ready_o, done_o, offsets_o, dist_o, band_pos_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset busy=%0b ready=%0b required 0 0", busy_o, ready_o);
    end
  endtask

  task automatic test_eo_directed;
    st_a[0] = 30; st_a[1] = 20; st_a[2] = -25; st_a[3] = -8;
    num_a[0] = 10; num_a[1] = 10; num_a[2] = 5; num_a[3] = 4;
    model_run(1'b0);
    do_run(1'b0, 1'b0);
    n_vec++; if (obs_off !== 16'hEB23) begin n_err++; $display("FAIL eo_offsets got=%h required=EB23", obs_off); end
    n_vec++; if (obs_dist !== 28'(-271)) begin n_err++; $display("FAIL eo_dist got=%0d required=-271", $signed(obs_dist)); end
    n_vec++; if (obs_pos !== 5'd0) begin n_err++; $display("FAIL eo_pos got=%0d required=0", obs_pos); end
    n_vec++; if (obs_done !== 1'b1 || obs_done_after !== 1'b0) begin
      n_err++; $display("FAIL eo_done_pulse got=%0b,%0b required=1,0", obs_done, obs_done_after); end
    n_vec++; if (obs_busy_after !== 1'b0) begin n_err++; $display("FAIL eo_busy_after got=%0b required=0", obs_busy_after); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (obs_gap[i] !== exp_gap[i]) begin n_err++; $display("FAIL eo_cycles entry=%0d got=%0d required=%0d", i, obs_gap[i], exp_gap[i]); end
    end
  endtask

  task automatic test_clip;
    st_a[0] = 100; st_a[1] = 55; st_a[2] = -7; st_a[3] = 0;
    num_a[0] = 2;  num_a[1] = 0;  num_a[2] = 3;  num_a[3] = 5;
    do_run(1'b0, 1'b0);
    n_vec++; if (obs_gap[0] !== 9) begin n_err++; $display("FAIL clip_div_cycles got=%0d required=9", obs_gap[0]); end
    n_vec++; if (obs_gap[1] !== 1) begin n_err++; $display("FAIL num0_skip_div got=%0d required=1", obs_gap[1]); end
    n_vec++; if (obs_off !== 16'h0E07) begin n_err++; $display("FAIL clip_offsets got=%h required=0E07", obs_off); end
    n_vec++; if (obs_dist !== 28'(-1318)) begin n_err++; $display("FAIL clip_dist got=%0d required=-1318", $signed(obs_dist)); end
  endtask

  task automatic test_sign;
    logic [15:0] c_off;
    longint c_dist;
    st_a[0] = -30; st_a[1] = 12; st_a[2] = -9; st_a[3] = 0;
    num_a[0] = 10; num_a[1] = 4; num_a[2] = 3; num_a[3] = 0;
`ifdef SAO_EO_SIGN_EN
    c_off = 16'h0D30; c_dist = -63;
`else
    c_off = 16'h0D3D; c_dist = -153;
`endif
    model_run(1'b0);
    do_run(1'b0, 1'b0);
    n_vec++; if (obs_off !== c_off) begin n_err++; $display("FAIL sign_offsets got=%h required=%h", obs_off, c_off); end
    n_vec++; if (obs_dist !== 28'(c_dist)) begin n_err++; $display("FAIL sign_dist got=%0d required=%0d", $signed(obs_dist), c_dist); end
    n_vec++; if (obs_gap[0] !== exp_gap[0]) begin n_err++; $display("FAIL sign_cycles got=%0d required=%0d", obs_gap[0], exp_gap[0]); end
  endtask

  task automatic test_bo_zero;
    for (int i = 0; i < 32; i++) begin st_a[i] = 0; num_a[i] = 0; end
    do_run(1'b1, 1'b0);
    n_vec++; if (obs_pos !== 5'd0) begin n_err++; $display("FAIL bo_zero_pos got=%0d required=0", obs_pos); end
    n_vec++; if (obs_dist !== 28'd0 || obs_off !== 16'h0) begin
      n_err++; $display("FAIL bo_zero_result dist=%0d off=%h required 0 0000", $signed(obs_dist), obs_off); end
    n_vec++; if (obs_done !== 1'b1) begin n_err++; $display("FAIL bo_zero_done got=%0b required=1", obs_done); end
  endtask

  task automatic test_bo_directed;
    for (int i = 0; i < 32; i++) begin st_a[i] = 0; num_a[i] = 0; end
    for (int i = 10; i < 14; i++) begin st_a[i] = 40; num_a[i] = 10; end
    do_run(1'b1, 1'b0);
    n_vec++; if (obs_off !== 16'h4444) begin n_err++; $display("FAIL bo_offsets got=%h required=4444", obs_off); end
    n_vec++; if (obs_dist !== 28'(-640)) begin n_err++; $display("FAIL bo_dist got=%0d required=-640", $signed(obs_dist)); end
    n_vec++; if (obs_pos !== 5'd10) begin n_err++; $display("FAIL bo_pos got=%0d required=10", obs_pos); end
  endtask

  task automatic test_random(input int runs, input bit inject, input bit force_eo);
    bit m;
    for (int r = 0; r < runs; r++) begin
      m = force_eo ? 1'b0 : 1'($urandom_range(0, 1));
      gen_random(m);
      model_run(m);
      do_run(m, inject);
      n_vec++; if (obs_off !== exp_off) begin n_err++; $display("FAIL rand_offsets run=%0d mode=%0b got=%h required=%h", r, m, obs_off, exp_off); end
      n_vec++; if (obs_dist !== 28'(exp_dist)) begin n_err++; $display("FAIL rand_dist run=%0d mode=%0b got=%0d required=%0d", r, m, $signed(obs_dist), exp_dist); end
      n_vec++; if (obs_pos !== exp_pos) begin n_err++; $display("FAIL rand_pos run=%0d got=%0d required=%0d", r, obs_pos, exp_pos); end
      n_vec++; if (obs_done !== 1'b1 || obs_done_after !== 1'b0) begin
        n_err++; $display("FAIL rand_done run=%0d got=%0b,%0b required=1,0", r, obs_done, obs_done_after); end
      for (int i = 0; i < (m ? 32 : 4); i++) begin
        n_vec++;
        if (obs_gap[i] !== exp_gap[i]) begin n_err++; $display("FAIL rand_cycles run=%0d entry=%0d got=%0d required=%0d", r, i, obs_gap[i], exp_gap[i]); end
      end
    end
  endtask

  task automatic test_abort;
    bit saw_done = 1'b0;
    @(negedge clk); start_i = 1'b1; mode_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    valid_i = 1'b1; b_state_i = 20'd500; b_num_i = 13'd3;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, ready_o, done_o, offsets_o, dist_o, band_pos_o} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs got busy=%0b ready=%0b done=%0b off=%h dist=%h pos=%0d required all 0",
               busy_o, ready_o, done_o, offsets_o, dist_o, band_pos_o);
    end
    valid_i = 1'b0;
    repeat (3) begin @(negedge clk); if (done_o) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done_o) saw_done = 1'b1; end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=%0b required=0", saw_done); end
    test_random(1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_eo_directed;
    test_clip;
    test_sign;
    test_bo_zero;
    test_bo_directed;
    test_random(8, 1'b0, 1'b0);
    test_random(3, 1'b1, 1'b0);
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
